// File: rtl/stream_src_mux_if.sv
// Bundle of the merged-stream signals between the sources, the mux and the
// downstream datapath. The mux uses the slave view; the environment around it
// (sources, host and sink) uses the master view.
interface stream_src_mux_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic                    isExternal;
  logic [SELW-1:0]         ext_sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SELW-1:0]         cur_ch;
  logic [CNT_W-1:0]        switch_count;

  modport slave (
    input  in_data, in_valid, isExternal, ext_sel, out_ready,
    output in_ready, out_data, out_valid, cur_ch, switch_count
  );

  modport master (
    output in_data, in_valid, isExternal, ext_sel, out_ready,
    input  in_ready, out_data, out_valid, cur_ch, switch_count
  );
endinterface

// File: rtl/stream_src_mux.sv
// Merges NUM_CH valid/ready sources onto one registered output stream.
// The host either pins a single channel (external mode) or lets the mux
// rotate round-robin over the valid channels (internal mode). A saturating
// counter records how often the served channel changes.
module stream_src_mux #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  stream_src_mux_if.slave     bus
);
  localparam int SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SELW-1:0] LAST_CH = SELW'(NUM_CH - 1);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SELW-1:0]  cur_ch_q;
  logic [CNT_W-1:0] switch_count_q;
  logic [SELW-1:0]  last_grant_q;

  logic             load_en;
  logic             granted;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  cand;
  logic             transfer;
  logic [WIDTH-1:0] grant_data;
  logic [NUM_CH-1:0] ready_vec;

  // The register can take a new word when it is empty or being drained this cycle
  assign load_en  = !out_valid_q || bus.out_ready;
  assign transfer = granted && load_en && !reset;

  // Pick the channel to serve: the pinned channel in external mode, otherwise
  // the first valid channel after the last one served, wrapping at NUM_CH-1
  always_comb begin
    granted = 1'b0;
    grant   = '0;
    cand    = last_grant_q;
    if (bus.isExternal) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ext_sel == SELW'(i) && bus.in_valid[i]) begin
          granted = 1'b1;
          grant   = SELW'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
        if (!granted && bus.in_valid[cand]) begin
          granted = 1'b1;
          grant   = cand;
        end
      end
    end
  end

  // Steer the granted channel's data and raise only its ready line
  always_comb begin
    grant_data = '0;
    ready_vec  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SELW'(i)) begin
        grant_data   = bus.in_data[i*WIDTH +: WIDTH];
        ready_vec[i] = transfer;
      end
    end
  end

  // Output register, round-robin pointer and channel-switch counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      cur_ch_q       <= '0;
      switch_count_q <= '0;
      last_grant_q   <= LAST_CH;
    end else if (transfer) begin
      out_data_q   <= grant_data;
      out_valid_q  <= 1'b1;
      cur_ch_q     <= grant;
      last_grant_q <= grant;
      if (grant != cur_ch_q && switch_count_q != {CNT_W{1'b1}}) begin
        switch_count_q <= switch_count_q + 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready     = ready_vec;
  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.cur_ch       = cur_ch_q;
  assign bus.switch_count = switch_count_q;
endmodule
